fp_sign_arbiter: RTL
====================

# fp_sign_arbiter

Round-robin arbiter that shares one IEEE-754 single-precision sign-manipulation unit among `NUM_REQ` requesters. Each request carries a 32-bit float and a 2-bit opcode (pass, negate, absolute, negative-absolute). The result is returned through a registered, back-pressured response port tagged with the requester index. It sits between the TPU lane controllers and the shared sign datapath, so the negate logic is instantiated once rather than per lane.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the requester tag. Derived; never overridden.
- `clk`  input  1  single clock; all state updates on its rising edge.
- `rst_n`  input  1  synchronous, active-low reset.
- `req_valid`  input  NUM_REQ  per-requester request valid.
- `req_ready`  output  NUM_REQ  per-requester accept; at most one bit high per cycle.
- `req_data`  input  NUM_REQ x 32  IEEE-754 single-precision operands.
- `req_op`  input  NUM_REQ x 2  opcode: 00 pass, 01 negate, 10 abs, 11 nabs.
- `rsp_valid`  output  1  result register holds a valid result.
- `rsp_ready`  input  1  consumer accepts the result.
- `rsp_data`  output  32  result bits.
- `rsp_id`  output  ID_W  index of the requester that produced the result.
- `op_count`  output  16  count of accepted requests, saturating at 0xFFFF.

## Operation
- Sign operation is bitwise on bit 31 only; bits 30:0 pass unchanged.
  - negate: bit31 is inverted.
  - abs: bit31 is forced to 0.
  - nabs: bit31 is forced to 1.
  - No special case for NaN, Inf, zero or denormals.
- Consequences: negate of +0.0 is -0.0 (0x80000000); abs of -0.0 is +0.0.
- Slot free condition: `slot_free = !rsp_valid || rsp_ready`.
- Grant rule: when the slot is free, grant the first requester with `req_valid` high, searching from `rr_ptr` upward and wrapping modulo NUM_REQ.
  - `req_ready[g]` is high for the granted requester only.
  - A handshake is `req_valid[i] && req_ready[i]`.
- `req_ready` is combinational from `req_valid`, `rsp_valid`, `rsp_ready` and `rr_ptr`. A requester must not make `req_valid` depend on `req_ready`.
- On a handshake:
  - `rsp_data` is loaded with the sign-unit output.
  - `rsp_id` is loaded with the grant index g.
  - `rsp_valid` is set to 1.
  - `rr_ptr` becomes (g+1) mod NUM_REQ.
  - `op_count` increments unless it is 0xFFFF.
- When `rsp_valid && rsp_ready` with no new grant, `rsp_valid` clears. `rsp_data` and `rsp_id` hold their last values.
- Stall: when `rsp_valid && !rsp_ready`, all `req_ready` are 0. `rsp_data`, `rsp_id` and `rr_ptr` hold.
- Requesters keep `req_valid`, `req_data` and `req_op` stable until accepted. The arbiter does not check this.
- With no `req_valid`, `rr_ptr` does not move.

## Timing
- Reset values (synchronous, rst_n low at a rising edge):
  - `rsp_valid` = 0, `rsp_data` = 0, `rsp_id` = 0, `op_count` = 0, `rr_ptr` = 0.
  - `req_ready` is combinationally 0 while `rst_n` is low.
- Latency: handshake at edge t gives `rsp_valid` = 1 after edge t, one cycle.
- Throughput: one result per cycle while `rsp_ready` stays high. A consume and a new accept in the same cycle is required: no bubble.
- Simultaneous requests: the N valid requesters are served in N consecutive cycles in rotating order. No requester waits more than NUM_REQ-1 grants.
- Reset mid-operation discards any held result. No partial response is emitted.

## Structure
- Package `fp_sign_pkg`:
  - enum `sign_op_e` {OP_PASS=2'b00, OP_NEG=2'b01, OP_ABS=2'b10, OP_NABS=2'b11}.
  - localparam `FP_W`=32.
  - localparam `FP_SIGN_BIT`=31.
- Sub-module `fp_sign_unit` (combinational):
  - inputs: `inputA` [31:0], `op` (`sign_op_e`); output: `out` [31:0].
  - With `op` = OP_NEG it is bit-identical to the existing negate unit.
- Top level holds the round-robin grant logic, the result register and `op_count`.

## Test plan
- Reset with all `req_valid` high: while `rst_n` = 0, `req_ready` = 0 and `rsp_valid` = 0. On the first cycle after release, requester 0 is granted.
- Requester 1 sends 0x40600000 (3.5) with OP_NEG -> next cycle `rsp_valid` = 1, `rsp_data` = 0xC0600000, `rsp_id` = 1.
- OP_ABS on 0xC0600000 -> 0x40600000; OP_NEG on 0x00000000 -> 0x80000000; OP_ABS on 0x80000000 -> 0x00000000; OP_NABS on 0x7FC00000 -> 0xFFC00000.
- All 4 requesters valid, `rsp_ready` = 1 -> `rsp_id` sequence 0,1,2,3,0 on consecutive cycles, with no bubbles.
- Hold `rsp_ready` = 0 for 5 cycles with results pending:
  - `rsp_data`/`rsp_id` stable and all `req_ready` = 0 during the hold.
  - On release, the next requester in rotation is granted in that same cycle.
- Preload `op_count` near saturation with 65540 accepts -> `op_count` stays 0xFFFF.

Source files
------------

// File: rtl/fp_sign_pkg.sv
// Shared types and constants for the shared IEEE-754 sign datapath and its arbiter.
package fp_sign_pkg;

    // Sign operation selected by each requester
    typedef enum logic [1:0] {
        OP_PASS = 2'b00,
        OP_NEG  = 2'b01,
        OP_ABS  = 2'b10,
        OP_NABS = 2'b11
    } sign_op_e;

    localparam int FP_W        = 32;
    localparam int FP_SIGN_BIT = 31;

    // Accepted-request counter width and its saturation value
    localparam int              CNT_W   = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage : fp_sign_pkg

// File: rtl/fp_sign_unit.sv
// Combinational single-precision sign manipulation: only bit 31 is touched,
// bits 30:0 pass through, with no special handling of NaN/Inf/zero/denormals.
module fp_sign_unit
    import fp_sign_pkg::*;
(
    input  logic [FP_W-1:0] inputA,
    input  sign_op_e        op,
    output logic [FP_W-1:0] out
);

    // Rewrite the sign bit according to the opcode
    always_comb begin
        out = inputA;
        case (op)
            OP_PASS: out[FP_SIGN_BIT] = inputA[FP_SIGN_BIT];
            OP_NEG:  out[FP_SIGN_BIT] = ~inputA[FP_SIGN_BIT];
            OP_ABS:  out[FP_SIGN_BIT] = 1'b0;
            OP_NABS: out[FP_SIGN_BIT] = 1'b1;
            default: out[FP_SIGN_BIT] = inputA[FP_SIGN_BIT];
        endcase
    end

endmodule : fp_sign_unit

// File: rtl/fp_sign_arbiter.sv
// Round-robin arbiter sharing one fp_sign_unit among NUM_REQ requesters.
// A single registered, back-pressured result slot is tagged with the
// requester index; a consume and a new accept may happen in the same cycle.
module fp_sign_arbiter
    import fp_sign_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0][FP_W-1:0]  req_data,
    input  logic [NUM_REQ-1:0][1:0]       req_op,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [FP_W-1:0]               rsp_data,
    output logic [ID_W-1:0]               rsp_id,
    output logic [CNT_W-1:0]              op_count
);

    // Architectural state
    logic              r_rsp_valid;
    logic [FP_W-1:0]   r_rsp_data;
    logic [ID_W-1:0]   r_rsp_id;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [CNT_W-1:0]  r_op_count;

    // Grant and datapath nets
    logic              w_slot_free;
    logic              w_gnt_any;
    logic [ID_W-1:0]   w_gnt_idx;
    logic              w_handshake;
    logic [ID_W-1:0]   w_ptr_nxt;
    logic [FP_W-1:0]   w_sel_data;
    sign_op_e          w_sel_op;
    logic [FP_W-1:0]   w_unit_out;

    // The result slot can take a new value if empty or being drained this cycle
    assign w_slot_free = !r_rsp_valid || rsp_ready;

    // Find the first valid requester at or after rr_ptr, wrapping modulo NUM_REQ
    always_comb begin : grant_search
        int unsigned v_idx;
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        v_idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            v_idx = int'(r_rr_ptr) + k;
            if (v_idx >= NUM_REQ) begin
                v_idx = v_idx - NUM_REQ;
            end
            if (!w_gnt_any && req_valid[ID_W'(v_idx)]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = ID_W'(v_idx);
            end
        end
    end

    // One-hot ready for the granted requester; forced low in reset or on stall
    always_comb begin
        req_ready = '0;
        if (rst_n && w_slot_free && w_gnt_any) begin
            req_ready[w_gnt_idx] = 1'b1;
        end
    end

    assign w_handshake = rst_n && w_slot_free && w_gnt_any;

    // Pointer advances to the slot after the winner
    assign w_ptr_nxt = (w_gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;

    // Operand mux in front of the single shared sign unit
    assign w_sel_data = req_data[w_gnt_idx];
    assign w_sel_op   = sign_op_e'(req_op[w_gnt_idx]);

    fp_sign_unit u_sign_unit (
        .inputA (w_sel_data),
        .op     (w_sel_op),
        .out    (w_unit_out)
    );

    // Result slot, round-robin pointer and saturating accept counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_id    <= '0;
            r_rr_ptr    <= '0;
            r_op_count  <= '0;
        end else begin
            if (w_handshake) begin
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= w_unit_out;
                r_rsp_id    <= w_gnt_idx;
                r_rr_ptr    <= w_ptr_nxt;
                if (r_op_count != CNT_MAX) begin
                    r_op_count <= r_op_count + 1'b1;
                end
            end else if (rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_rsp_id;
    assign op_count  = r_op_count;

endmodule : fp_sign_arbiter
